// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder
//   Pipelined carry-lookahead adder/subtractor. The operands are cut into
//   NBLK = WIDTH/BLOCK blocks. Pipeline stage k resolves block k with a full
//   generate/propagate lookahead and registers the block carry-out for stage k+1.
//   Operand blocks that are not yet used travel down the pipe, skewed, so that
//   each stage always works on the lowest block of its operand registers.
//
// Ports
//   i_clk, i_rst         clock; synchronous active-high reset
//   i_valid / o_ready    upstream handshake (o_ready = i_ready | ~o_valid)
//   in_a, in_b           operands (WIDTH bits)
//   i_cin                carry-in for add, borrow-in for subtract
//   i_sub                0: A+B+cin, 1: A-B-cin
//   o_valid / i_ready    downstream handshake
//   out_sum              result (WIDTH bits)
//   o_cout               raw carry out of the MSB (for subtract, 1 = no borrow)
//   o_ovf                two's-complement signed overflow
//
// Latency is NBLK edges counted from the accepting edge. All stages advance
// together whenever the output is free or is being consumed.

module pipelined_cla_adder #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             i_cin,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             o_cout,
  output logic             o_ovf
);

  localparam int NBLK = WIDTH / BLOCK;
  // The last stage stores no operands, so only NBLK-1 operand registers exist.
  localparam int OPS  = (NBLK > 1) ? NBLK - 1 : 1;

  if (WIDTH % BLOCK != 0) begin : g_bad_block
    $error("pipelined_cla_adder: WIDTH must be a multiple of BLOCK");
  end

  // All carries of one block in two-level lookahead form. Each carry is built
  // directly from g/p terms and the block carry-in, never from the previous
  // carry, so the in-block depth does not grow as a ripple chain.
  // Returns c[0] = cin ... c[BLOCK] = block carry-out.
  function automatic logic [BLOCK:0] cla_carries(
    input logic [BLOCK-1:0] a,
    input logic [BLOCK-1:0] b,
    input logic             cin
  );
    logic [BLOCK:0]   c;
    logic [BLOCK-1:0] g;
    logic [BLOCK-1:0] p;
    logic             term;
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < BLOCK; i++) begin
      term = cin;
      for (int j = 0; j <= i; j++) term = term & p[j];
      c[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) term = term & p[m];
        c[i+1] = c[i+1] | term;
      end
    end
    return c;
  endfunction

  // Stage registers (index = stage number).
  logic [WIDTH-1:0] sum_p  [NBLK];
  logic [WIDTH-1:0] a_p    [OPS];
  logic [WIDTH-1:0] b_p    [OPS];
  logic [NBLK-1:0]  cy_p;
  logic [NBLK-1:0]  vld_p;
  logic             cmsb_p;

  logic [WIDTH-1:0] sum_nxt [NBLK];
  logic [WIDTH-1:0] a_nxt   [OPS];
  logic [WIDTH-1:0] b_nxt   [OPS];
  logic [NBLK-1:0]  cy_nxt;
  logic [NBLK-1:0]  vld_nxt;
  logic             cmsb_nxt;

  logic [WIDTH-1:0] a_cur;
  logic [WIDTH-1:0] b_cur;
  logic [WIDTH-1:0] sum_base;
  logic             c_cur;
  logic             v_cur;
  logic [BLOCK:0]   c_blk;
  logic             en;

  assign o_valid = vld_p[NBLK-1];
  assign out_sum = sum_p[NBLK-1];
  assign o_cout  = cy_p[NBLK-1];
  assign o_ovf   = cmsb_p ^ cy_p[NBLK-1];
  assign o_ready = i_ready | ~o_valid;
  assign en      = o_ready;

  always_comb begin
    for (int k = 0; k < NBLK; k++) sum_nxt[k] = '0;
    for (int k = 0; k < OPS; k++) begin
      a_nxt[k] = '0;
      b_nxt[k] = '0;
    end
    cy_nxt   = '0;
    vld_nxt  = '0;
    cmsb_nxt = 1'b0;
    a_cur    = '0;
    b_cur    = '0;
    sum_base = '0;
    c_cur    = 1'b0;
    v_cur    = 1'b0;
    c_blk    = '0;
    for (int k = 0; k < NBLK; k++) begin
      if (k == 0) begin
        // Subtract as A + ~B + ~borrow.
        a_cur    = in_a;
        b_cur    = i_sub ? ~in_b : in_b;
        c_cur    = i_sub ? ~i_cin : i_cin;
        sum_base = '0;
        v_cur    = i_valid;
      end else begin
        a_cur    = a_p[(k > 0) ? k - 1 : 0];
        b_cur    = b_p[(k > 0) ? k - 1 : 0];
        c_cur    = cy_p[(k > 0) ? k - 1 : 0];
        sum_base = sum_p[k-1];
        v_cur    = vld_p[(k > 0) ? k - 1 : 0];
      end
      c_blk                          = cla_carries(a_cur[BLOCK-1:0], b_cur[BLOCK-1:0], c_cur);
      sum_nxt[k]                     = sum_base;
      sum_nxt[k][k*BLOCK +: BLOCK]   = a_cur[BLOCK-1:0] ^ b_cur[BLOCK-1:0] ^ c_blk[BLOCK-1:0];
      cy_nxt[k]                      = c_blk[BLOCK];
      vld_nxt[k]                     = v_cur;
      // Shift the consumed block out so the next stage sees its block at bit 0.
      if (k < NBLK - 1) begin
        a_nxt[k] = a_cur >> BLOCK;
        b_nxt[k] = b_cur >> BLOCK;
      end
      if (k == NBLK - 1) cmsb_nxt = c_blk[BLOCK-1];
    end
  end

  // ---- stage boundary: every stage register advances together on en ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < NBLK; k++) sum_p[k] <= '0;
      for (int k = 0; k < OPS; k++) begin
        a_p[k] <= '0;
        b_p[k] <= '0;
      end
      cy_p   <= '0;
      vld_p  <= '0;
      cmsb_p <= 1'b0;
    end else if (en) begin
      for (int k = 0; k < NBLK; k++) sum_p[k] <= sum_nxt[k];
      for (int k = 0; k < OPS; k++) begin
        a_p[k] <= a_nxt[k];
        b_p[k] <= b_nxt[k];
      end
      cy_p   <= cy_nxt;
      vld_p  <= vld_nxt;
      cmsb_p <= cmsb_nxt;
    end
  end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb_pipelined_cla_adder
//   Bench for pipelined_cla_adder (WIDTH=32, BLOCK=8, four stages).
//   Expected results come from an arithmetic model ({ovf, cout, sum} from
//   plain integer add/subtract and signed range checks) held in a queue of
//   accepted beats; a single negedge monitor pops and compares on every
//   output transfer, checks o_ready and stall stability every cycle.
//   Directed sequences cover reset, latency, the flag corner cases,
//   backpressure and reset while beats are in flight; then random traffic.

module tb_pipelined_cla_adder;

  localparam int W    = 32;
  localparam int B    = 8;
  localparam int NBLK = W / B;
  localparam longint MAXS = (longint'(1) <<< (W - 1)) - 1;
  localparam longint MINS = -MAXS - 1;

  logic         clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_valid = 1'b1;
  logic         o_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         i_cin = 1'b0;
  logic         i_sub = 1'b0;
  logic         o_valid;
  logic         i_ready = 1'b1;
  logic [W-1:0] out_sum;
  logic         o_cout;
  logic         o_ovf;

  int checks = 0;
  int errors = 0;
  int popped = 0;

  logic [W+1:0] exp_q[$];
  logic         held_v = 1'b0;
  logic [W+2:0] held   = '0;

  pipelined_cla_adder #(.WIDTH(W), .BLOCK(B)) dut (
    .i_clk   (clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .in_a    (in_a),
    .in_b    (in_b),
    .i_cin   (i_cin),
    .i_sub   (i_sub),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .out_sum (out_sum),
    .o_cout  (o_cout),
    .o_ovf   (o_ovf)
  );

  always #5 clk = ~clk;

  // {ovf, cout, sum} from integer arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
    longint     sa, sb, r;
    logic [W:0] u;
    logic       cout, ovf;
    sa = $signed(a);
    sb = $signed(b);
    if (!sub) begin
      u    = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
      cout = u[W];
      r    = sa + sb + longint'(cin);
    end else begin
      u    = {1'b0, a} - {1'b0, b} - (W+1)'(cin);
      cout = ({1'b0, a} >= ({1'b0, b} + (W+1)'(cin)));
      r    = sa - sb - longint'(cin);
    end
    ovf = (r > MAXS) || (r < MINS);
    return {ovf, cout, u[W-1:0]};
  endfunction

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  // Monitor: inputs change #1 after posedge, so negedge sees what the next edge uses.
  always @(negedge clk) begin
    if (i_rst) begin
      exp_q.delete();
      held_v = 1'b0;
    end else begin
      chk("o_ready_rule", {63'd0, o_ready}, {63'd0, (i_ready | ~o_valid)});
      if (held_v)
        chk("stall_hold", {61'd0, o_valid, out_sum, o_cout, o_ovf}, {61'd0, held});
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_result", {63'd0, o_valid}, 64'd0);
        end else begin
          chk("result", {30'd0, o_ovf, o_cout, out_sum}, {30'd0, exp_q.pop_front()});
          popped++;
        end
      end
      held_v = o_valid && !i_ready;
      held   = {o_valid, out_sum, o_cout, o_ovf};
      if (i_valid && o_ready) exp_q.push_back(model(in_a, in_b, i_cin, i_sub));
    end
  end

  // Present a beat (caller is #1 after a posedge) and hold it until accepted.
  task automatic send_beat(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input logic sub);
    logic acc;
    in_a = a; in_b = b; i_cin = cin; i_sub = sub; i_valid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      acc = o_ready;
      @(posedge clk);
      #1;
      if (acc) return;
    end
    chk("send_timeout", 64'd1, 64'd0);
  endtask

  // Single beat into an empty pipe; exact latency and literal result.
  task automatic directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub, input logic [W+1:0] exp);
    send_beat(a, b, cin, sub);
    i_valid = 1'b0;
    repeat (NBLK - 2) @(posedge clk);
    #1;
    chk({name, "_early"}, {63'd0, o_valid}, 64'd0);
    @(posedge clk);
    #1;
    chk({name, "_valid"}, {63'd0, o_valid}, 64'd1);
    chk(name, {30'd0, o_ovf, o_cout, out_sum}, {30'd0, exp});
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] snap_sum;
  logic         snap_cout, snap_ovf;
  int           pop_base;

  initial begin
    // Model pins.
    chk("pin_add_wrap", model(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0), {2'b01, 32'h0000_0000});
    chk("pin_add_ovf",  model(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0), {2'b10, 32'h8000_0000});
    chk("pin_sub_ovf",  model(32'h8000_0000, 32'h1, 1'b0, 1'b1), {2'b11, 32'h7FFF_FFFF});
    chk("pin_sub_brw",  model(32'h5, 32'h7, 1'b1, 1'b1),         {2'b00, 32'hFFFF_FFFD});

    // Reset held for 3 edges with traffic offered.
    in_a = 32'h1234_5678; in_b = 32'h1111_1111;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst_outputs", {30'd0, o_valid, out_sum, o_cout, o_ovf}, 64'd0);
      chk("rst_ready", {63'd0, o_ready}, 64'd1);
    end
    i_rst = 1'b0;
    i_valid = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      chk("post_rst_no_ghost", {63'd0, o_valid}, 64'd0);
    end

    // Directed flag and latency cases.
    directed("add_wrap",  32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, {2'b01, 32'h0000_0000});
    directed("add_ovf",   32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, {2'b10, 32'h8000_0000});
    directed("sub_ovf",   32'h8000_0000, 32'h1, 1'b0, 1'b1, {2'b11, 32'h7FFF_FFFF});
    directed("sub_borrow", 32'h5, 32'h7, 1'b1, 1'b1,        {2'b00, 32'hFFFF_FFFD});

    // Backpressure: 8 back-to-back adds with a 3-cycle stall.
    pop_base = popped;
    fork
      begin
        for (int i = 0; i < 8; i++) send_beat(W'(i), W'(16 * i), 1'b0, 1'b0);
        i_valid = 1'b0;
      end
      begin
        int n;
        n = 0;
        while (!o_valid && n < 50) begin
          @(posedge clk);
          #1;
          n++;
        end
        chk("bp_first_valid", {63'd0, o_valid}, 64'd1);
        i_ready   = 1'b0;
        snap_sum  = out_sum;
        snap_cout = o_cout;
        snap_ovf  = o_ovf;
        repeat (3) begin
          @(posedge clk);
          #1;
          chk("bp_ready_low", {63'd0, o_ready}, 64'd0);
          chk("bp_frozen", {31'd0, o_valid, out_sum, o_cout, o_ovf},
              {31'd0, 1'b1, snap_sum, snap_cout, snap_ovf});
        end
        i_ready = 1'b1;
      end
    join
    repeat (NBLK + 3) @(posedge clk);
    #1;
    chk("bp_count", 64'(popped - pop_base), 64'd8);

    // Reset while two beats are in flight.
    send_beat(32'hAAAA_0000, 32'h0000_5555, 1'b0, 1'b0);
    send_beat(32'h0F0F_0F0F, 32'h0101_0101, 1'b1, 1'b1);
    i_valid = 1'b0;
    i_rst   = 1'b1;
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    chk("midrst_valid", {63'd0, o_valid}, 64'd0);
    pop_base = popped;
    repeat (8) @(posedge clk);
    #1;
    chk("midrst_dropped", 64'(popped - pop_base), 64'd0);

    // Random traffic with random backpressure and corner-biased operands.
    for (int t = 0; t < 10000; t++) begin
      i_valid = ($urandom_range(3) != 0);
      i_ready = ($urandom_range(3) != 0);
      case ($urandom_range(7))
        0:       in_a = 32'hFFFF_FFFF;
        1:       in_a = 32'h8000_0000;
        2:       in_a = 32'h7FFF_FFFF;
        default: in_a = $urandom;
      endcase
      case ($urandom_range(7))
        0:       in_b = 32'hFFFF_FFFF;
        1:       in_b = 32'h0000_0001;
        2:       in_b = 32'h8000_0000;
        default: in_b = $urandom;
      endcase
      i_cin = $urandom_range(1) == 1;
      i_sub = $urandom_range(1) == 1;
      @(posedge clk);
      #1;
    end

    // Drain.
    i_valid = 1'b0;
    i_ready = 1'b1;
    repeat (NBLK + 3) @(posedge clk);
    #1;
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    chk("drain_idle", {63'd0, o_valid}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
